// File: rtl/irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : irq_aggregator
// Purpose  : Avalon-MM slave interrupt controller. Synchronises up to 16
//            peripheral irq lines, latches each as edge or level, masks and
//            prioritises them (index 0 highest) and drives one registered irq
//            to the CPU, with a programmable hold-off between assertions.
// Ports    : clk        - system clock, rising edge
//            reset_n    - synchronous active-low reset
//            address    - register word address (0..7)
//            chipselect - slave select
//            write_n    - active-low write strobe
//            writedata  - 16-bit write data
//            irq_in     - peripheral requests, active-high, may be async
//            readdata   - registered read data (1-cycle latency)
//            irq        - registered interrupt to CPU
// Registers: 0 STATUS (R, W1C edge bits)  1 MASK (RW)  2 MODE (RW, 1=edge)
//            3 VECTOR (RO)  4 HOLDOFF (RW)  5 FORCE (WO)  6,7 reserved
// Revision : 1.0 - initial release
// ============================================================================
module irq_aggregator #(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [15:0]      writedata,
    input  logic [N_IRQ-1:0] irq_in,
    output logic [15:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_MASK    = 3'd1;
    localparam logic [2:0] c_ADDR_MODE    = 3'd2;
    localparam logic [2:0] c_ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] c_ADDR_HOLDOFF = 3'd4;
    localparam logic [2:0] c_ADDR_FORCE   = 3'd5;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ASSERT  = 2'd1;
    localparam logic [1:0] c_ST_HOLDOFF = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [N_IRQ-1:0] r_s_d;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_latched;
    logic [15:0]      r_holdoff;
    logic [15:0]      r_cnt;
    logic [1:0]       r_state;
    logic [15:0]      r_readdata;
    logic             r_irq;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             w_wr;
    logic             w_wr_status;
    logic             w_wr_mask;
    logic             w_wr_mode;
    logic             w_wr_holdoff;
    logic             w_wr_force;
    logic [N_IRQ-1:0] w_wdata;
    logic [N_IRQ-1:0] w_s;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_set;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_mode_next;
    logic [N_IRQ-1:0] w_latched_next;
    logic [N_IRQ-1:0] w_pending;
    logic [N_IRQ-1:0] w_req;
    logic             w_active;
    logic [3:0]       w_vec_idx;
    logic [15:0]      w_rdata;
    logic [1:0]       w_state_next;
    logic [15:0]      w_cnt_next;

    assign w_wr         = chipselect & ~write_n;
    assign w_wr_status  = w_wr && (address == c_ADDR_STATUS);
    assign w_wr_mask    = w_wr && (address == c_ADDR_MASK);
    assign w_wr_mode    = w_wr && (address == c_ADDR_MODE);
    assign w_wr_holdoff = w_wr && (address == c_ADDR_HOLDOFF);
    assign w_wr_force   = w_wr && (address == c_ADDR_FORCE);
    // Bits at or above N_IRQ are simply not captured.
    assign w_wdata      = writedata[N_IRQ-1:0];

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    // Set sources only act on inputs currently in edge mode; set beats
    // a simultaneous W1C clear. Masking with the post-write MODE discards
    // the latch on edge->level and keeps level inputs' latch at zero, so a
    // level->edge switch always starts from an empty latch.
    assign w_set          = (w_rise | (w_wr_force ? w_wdata : '0)) & r_mode;
    assign w_clr          = w_wr_status ? w_wdata : '0;
    assign w_mode_next    = w_wr_mode ? w_wdata : r_mode;
    assign w_latched_next = ((r_latched & ~w_clr) | w_set) & w_mode_next;

    // Latch is always zero for level inputs, so OR-ing the live level is safe.
    assign w_pending = r_latched | (w_s & ~r_mode);
    assign w_req     = w_pending & r_mask;
    assign w_active  = |w_req;

    // Lowest requesting index wins; scan downward so the last hit is lowest.
    always_comb begin
        w_vec_idx = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_vec_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            c_ADDR_STATUS:  w_rdata[N_IRQ-1:0] = w_pending;
            c_ADDR_MASK:    w_rdata[N_IRQ-1:0] = r_mask;
            c_ADDR_MODE:    w_rdata[N_IRQ-1:0] = r_mode;
            c_ADDR_VECTOR:  w_rdata = {w_active, 11'b0, w_vec_idx};
            c_ADDR_HOLDOFF: w_rdata = r_holdoff;
            default:        w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // irq state machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_active) begin
                    w_state_next = c_ST_ASSERT;
                end
            end
            c_ST_ASSERT: begin
                if (!w_active) begin
                    if (r_holdoff != 16'd0) begin
                        w_state_next = c_ST_HOLDOFF;
                        w_cnt_next   = r_holdoff - 16'd1;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            c_ST_HOLDOFF: begin
                // Counter parks at zero rather than wrapping.
                if (r_cnt == 16'd0) begin
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_s_d      <= '0;
            r_mask     <= '0;
            r_mode     <= '0;
            r_latched  <= '0;
            r_holdoff  <= '0;
            r_cnt      <= '0;
            r_state    <= c_ST_IDLE;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_sync[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_s_d     <= w_s;
            r_mode    <= w_mode_next;
            r_latched <= w_latched_next;
            if (w_wr_mask) begin
                r_mask <= w_wdata;
            end
            if (w_wr_holdoff) begin
                r_holdoff <= writedata;
            end
            r_cnt      <= w_cnt_next;
            r_state    <= w_state_next;
            r_readdata <= w_rdata;
            // irq tracks the registered state exactly: high only in ASSERT.
            r_irq      <= (w_state_next == c_ST_ASSERT);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_aggregator
// Purpose  : Self-checking bench for irq_aggregator. A cycle-level reference
//            model predicts readdata and irq; directed scenarios add literal
//            expectations, followed by randomized bus and irq traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_aggregator;

    localparam int c_N = 8;
    localparam int c_S = 2;

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [15:0]      writedata;
    logic [c_N-1:0]   irq_in;
    logic [15:0]      readdata;
    logic             irq;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    irq_aggregator #(.N_IRQ(c_N), .SYNC_STAGES(c_S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_in     (irq_in),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: per-input view of the rules, one step per edge.
    // ------------------------------------------------------------------
    logic [c_N-1:0] m_sq [c_S];
    logic [c_N-1:0] m_sd, m_lat, m_mode, m_mask;
    logic [15:0]    m_hold;
    int             m_block;
    logic           m_irq;
    logic [15:0]    m_rd;

    task automatic model_step();
        logic [c_N-1:0] s, pend, rise, nl;
        logic [15:0]    rd;
        bit             act, wr;
        if (!reset_n) begin
            for (int j = 0; j < c_S; j++) m_sq[j] = '0;
            m_sd = '0; m_lat = '0; m_mode = '0; m_mask = '0;
            m_hold = '0; m_block = 0; m_irq = 1'b0; m_rd = '0;
            return;
        end
        s = m_sq[c_S-1];
        for (int i = 0; i < c_N; i++) pend[i] = m_mode[i] ? m_lat[i] : s[i];
        act = ((pend & m_mask) != '0);
        rd = '0;
        case (address)
            3'd0: rd = {8'h00, pend};
            3'd1: rd = {8'h00, m_mask};
            3'd2: rd = {8'h00, m_mode};
            3'd3: begin
                if (act) begin
                    rd[15] = 1'b1;
                    for (int i = c_N - 1; i >= 0; i--)
                        if (pend[i] && m_mask[i]) rd[3:0] = 4'(i);
                end
            end
            3'd4: rd = m_hold;
            default: rd = '0;
        endcase
        wr = chipselect && !write_n;
        rise = s & ~m_sd;
        for (int i = 0; i < c_N; i++) begin
            if (!m_mode[i])
                nl[i] = 1'b0;
            else if (rise[i] || (wr && address == 3'd5 && writedata[i]))
                nl[i] = 1'b1;
            else if (wr && address == 3'd0 && writedata[i])
                nl[i] = 1'b0;
            else
                nl[i] = m_lat[i];
        end
        if (wr && address == 3'd2) m_mode = writedata[c_N-1:0];
        for (int i = 0; i < c_N; i++) if (!m_mode[i]) nl[i] = 1'b0;
        m_lat = nl;
        if (wr && address == 3'd1) m_mask = writedata[c_N-1:0];
        // irq: drop when nothing is active, then stay low for m_hold extra
        // edges before a new request may be honoured.
        if (m_irq) begin
            if (!act) begin
                m_irq = 1'b0;
                m_block = int'(m_hold);
            end
        end else if (m_block > 0) begin
            m_block = m_block - 1;
        end else if (act) begin
            m_irq = 1'b1;
        end
        if (wr && address == 3'd4) m_hold = writedata;
        m_sd = s;
        for (int j = c_S - 1; j > 0; j--) m_sq[j] = m_sq[j-1];
        m_sq[0] = irq_in;
        m_rd = rd;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of DUT against model, away from the active edge.
    int fail_prints = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checks++;
                if (readdata !== m_rd) begin
                    errors++;
                    if (fail_prints < 30) begin
                        fail_prints++;
                        $display("FAIL model_readdata t=%0t addr=%0d: got %h expected %h",
                                 $time, address, readdata, m_rd);
                    end
                end
                checks++;
                if (irq !== m_irq) begin
                    errors++;
                    if (fail_prints < 30) begin
                        fail_prints++;
                        $display("FAIL model_irq t=%0t: got %b expected %b", $time, irq, m_irq);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers (all called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [15:0] exp, input string name);
        address = a;
        tick();
        chk(name, readdata, exp);
    endtask

    task automatic wait_irq(input logic val, input int max, input string name);
        int n = 0;
        while (irq !== val && n < max) begin
            tick();
            n++;
        end
        chk(name, {15'b0, irq}, {15'b0, val});
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int low;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; irq_in = '0;
        repeat (2) tick();
        check_en = 1'b1;
        tick();
        reset_n = 1'b1;

        // Reset state: every address reads zero, irq low.
        for (int a = 0; a < 8; a++) rd_chk(3'(a), 16'h0000, $sformatf("reset_read_%0d", a));
        chk("reset_irq", {15'b0, irq}, 16'h0000);

        // Edge mode on input 0.
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        repeat (3) tick();
        chk("edge_irq_rise", {15'b0, irq}, 16'h0001);
        rd_chk(3'd0, 16'h0001, "edge_status");
        rd_chk(3'd3, 16'h8000, "edge_vector");
        wr(3'd0, 16'h0001);
        chk("edge_irq_still_high", {15'b0, irq}, 16'h0001);
        tick();
        chk("edge_irq_fall", {15'b0, irq}, 16'h0000);

        // Level mode on inputs 1 and 2.
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0006);
        irq_in[2:1] = 2'b11;
        repeat (4) tick();
        rd_chk(3'd3, 16'h8001, "level_vector_1");
        irq_in[1] = 1'b0;
        repeat (4) tick();
        rd_chk(3'd3, 16'h8002, "level_vector_2");
        wr(3'd0, 16'h0006);
        rd_chk(3'd0, 16'h0004, "level_status_w1c_ignored");
        chk("level_irq_held", {15'b0, irq}, 16'h0001);
        irq_in[2] = 1'b0;
        wait_irq(1'b0, 8, "level_irq_drop");
        rd_chk(3'd3, 16'h0000, "level_vector_none");

        // Hold-off: minimum low time between assertions is HOLDOFF+1.
        wr(3'd2, 16'h0008);
        wr(3'd1, 16'h0008);
        for (int h = 10; h >= 0; h -= 10) begin
            wr(3'd4, 16'(h));
            irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
            wait_irq(1'b1, 10, $sformatf("holdoff%0d_first", h));
            irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
            wr(3'd0, 16'h0008);
            tick();
            low = 0;
            while (irq === 1'b0 && low < 200) begin
                low++;
                tick();
            end
            chk($sformatf("holdoff%0d_low_cycles", h), 16'(low), 16'(h + 1));
            wr(3'd0, 16'h0008);
            wait_irq(1'b0, 8, $sformatf("holdoff%0d_cleanup", h));
            repeat (15) tick();
        end

        // Set beats clear on the same edge; FORCE ignores level inputs.
        wr(3'd1, 16'h0000);
        wr(3'd2, 16'h0010);
        wr(3'd0, 16'h00FF);
        irq_in[4] = 1'b1; tick(); irq_in[4] = 1'b0;
        tick();
        wr(3'd0, 16'h0010);
        rd_chk(3'd0, 16'h0010, "set_wins_over_clear");
        wr(3'd5, 16'h0020);
        rd_chk(3'd0, 16'h0010, "force_level_ignored");
        rd_chk(3'd5, 16'h0000, "force_reads_zero");

        // Reset during hold-off with everything pending.
        wr(3'd2, 16'h00FF);
        wr(3'd1, 16'h00FF);
        wr(3'd4, 16'd100);
        wr(3'd5, 16'h00FF);
        wait_irq(1'b1, 10, "rst_pre_irq");
        wr(3'd0, 16'h00FF);
        wait_irq(1'b0, 8, "rst_enter_holdoff");
        wr(3'd5, 16'h00FF);
        rd_chk(3'd0, 16'h00FF, "rst_pending_ff");
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("rst_irq_low", {15'b0, irq}, 16'h0000);
        rd_chk(3'd0, 16'h0000, "rst_status");
        rd_chk(3'd1, 16'h0000, "rst_mask");
        rd_chk(3'd4, 16'h0000, "rst_holdoff");
        repeat (5) tick();
        chk("rst_irq_idle", {15'b0, irq}, 16'h0000);

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = 16'($urandom);
            if (address == 3'd4) writedata = writedata & 16'h001F;
            for (int i = 0; i < c_N; i++)
                if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
            reset_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/irq_aggregator.md
Name: irq_aggregator

Overview:
- Avalon-MM slave interrupt controller that sits directly downstream of the interval timers and other peripheral slaves.
- Collects up to 16 peripheral irq lines, for example sys_clk_timer.irq.
- Latches them per-input as edge or level, masks and prioritises them, and drives one irq line to the Nios CPU.
- Provides a vector register and a programmable hold-off that rate-limits irq re-assertion.

Parameters:
N_IRQ, 8, number of interrupt inputs (1..16); index 0 is highest priority.
SYNC_STAGES, 2, synchroniser flops per input (>=2).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset_n  input  1  reset, synchronous and active-low.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe.
writedata  input  16  write data.
irq_in  input  N_IRQ  peripheral interrupt requests, active-high, possibly asynchronous.
readdata  output  16  registered read data.
irq  output  1  registered interrupt to CPU.

Behaviour:
- Reset: synchronous, active-low.
  - Sampled at the clk edge: all flops clear; irq=0, readdata=0, state=IDLE.
  - MASK, MODE, HOLDOFF, latched pending, synchroniser and edge-history flops all clear.
  - Asserting reset mid-operation (any state, hold-off running) takes full effect at the next edge.
- Write strobe is chipselect && !write_n. Writes take effect at the next edge; there are no wait states.
- Register map; bits at or above N_IRQ read 0 and ignore writes:
  - 0 STATUS: reads pending. A write-1 clears latched edge bits; level bits ignore it.
  - 1 MASK: R/W; 1 = enabled.
  - 2 MODE: R/W; 1 = edge, 0 = level.
  - 3 VECTOR: RO. Bit15 = any (pending & MASK). [3:0] = lowest index with pending&MASK set, 0 if none. Other bits 0.
  - 4 HOLDOFF: R/W, 16-bit count of cycles.
  - 5 FORCE: WO, reads 0. Writing 1 sets the latched pending bit for edge-mode inputs only; level-mode bits ignore it.
  - 6, 7: read 0, writes ignored.
- readdata is registered every cycle from the address mux, regardless of chipselect. Read latency is 1 cycle.
- Input path: irq_in[i] goes through a SYNC_STAGES flop chain to s[i]. A history flop gives a rise event: rise[i] = s[i] & !s_d[i].
- Pending, edge mode:
  - The latched bit sets on rise or FORCE.
  - It clears on STATUS write-1.
  - A set and a clear in the same cycle: set wins.
- Pending, level mode: pending[i] = s[i], live. The latched bit is forced to 0 while the input is in level mode.
- A MODE write edge→level discards the latched bit. A MODE write level→edge starts with latched=0, and s_d is preserved.
- Latency from irq_in rising (stable before edge k):
  - s visible at edge k+SYNC_STAGES-1.
  - Edge latch set at edge k+SYNC_STAGES; STATUS then reads 1 via readdata one cycle after the read.
- active = |(pending & MASK), computed combinationally from registered state.
- irq FSM; irq is registered and equals 1 only in ASSERT:
  - IDLE: if active, go to ASSERT; irq rises the following edge.
  - ASSERT: when active=0, go to HOLDOFF if HOLDOFF!=0 (load cnt=HOLDOFF-1), else go to IDLE.
  - HOLDOFF: irq=0. cnt decrements each cycle. At cnt==0 go to IDLE. Pending bits keep accumulating during hold-off.
  - A HOLDOFF write during the hold-off state does not alter the running cnt.
- irq therefore has a minimum low time of HOLDOFF+1 cycles between assertions (1 cycle when HOLDOFF=0).
- Clearing MASK while in ASSERT is treated exactly like pending clearing.
- The counter is 16 bits and does not wrap: it stops at 0. HOLDOFF=0xFFFF gives 65535 hold-off cycles.

Test Plan:
- Reset, then read all 8 addresses → readdata=0x0000 each; irq=0 throughout.
- MODE=0x01, MASK=0x01, pulse irq_in[0] high for 1 cycle:
  - STATUS reads 0x0001 and irq=1 within SYNC_STAGES+2 cycles; VECTOR reads 0x8000.
  - Write STATUS=0x0001 → irq falls 2 cycles later.
- MODE=0x00, MASK=0x06, hold irq_in[1] and irq_in[2] high → VECTOR=0x8001.
  - Drop irq_in[1] → VECTOR=0x8002.
  - A STATUS write-1 has no effect; dropping irq_in[2] clears irq.
- Edge mode, HOLDOFF=10:
  - Pulse irq_in[3], clear it, pulse again immediately → second irq assertion occurs no earlier than 11 cycles after irq fell.
  - Same sequence with HOLDOFF=0 → re-asserts after 1 low cycle.
- Edge mode: STATUS write-1 on bit 4 in the same cycle as a rise on bit 4 → bit 4 stays 1.
  - FORCE=0x0020 with bit 5 in level mode → no change.
- Assert reset_n=0 for one edge while in HOLDOFF with pending=0x00FF → next cycle irq=0, STATUS=0, state IDLE; MASK=0.
